// File: rtl/chip_pkg.sv
// Shared types for the chip-level result packer: the captured record layout,
// the output FSM state encoding and the default header sync byte.
// Imported by result_fifo and chip_result_packer.
package chip_pkg;

    // One captured record; field order is the on-wire record order,
    // most significant field first.
    typedef struct packed {
        logic [3:0]  flags;  // {cout1, cout2, comp_out1, comp_out2}
        logic [3:0]  seq;    // capture sequence number, wraps 15 -> 0
        logic [15:0] mux;    // mux result
        logic [31:0] prod;   // 16x16 product
    } result_rec_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pk_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage : chip_pkg

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO of result records.
// Ports: clk/rst (sync active-high), wr_en/wr_data push, rd_en pops and
//        rd_data shows the head combinationally, full/empty/count status.
// Latency: a write is visible at rd_data the cycle after wr_en. A write while
// full is taken only if rd_en pops in the same cycle; DEPTH must be a power
// of two, at least 2, so the pointers wrap by natural overflow.
module result_fifo
    import chip_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  result_rec_t              wr_data,
    input  logic                     rd_en,
    output result_rec_t              rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    result_rec_t          r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    logic                 w_do_wr;
    logic                 w_do_rd;

    assign full    = (r_count == DEPTH[AW:0]);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // When full, wr_ptr == rd_ptr; the head is read combinationally this
    // cycle before the write lands at the edge, so full-plus-pop is safe.
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);

    // Storage carries no reset: contents are qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : result_fifo

// File: rtl/chip_result_packer.sv
// Captures {flags, seq, mux_out, m32_out} records into a FIFO and streams each
// one out as four 16-bit beats: {flags,seq,SYNC}, mux, prod[31:16], prod[15:0].
// Ports: clk/rst (sync active-high); capture/mux_out/m32_out/flags record
//        input; clr_ovf clears the sticky overflow; out_valid/out_ready/
//        out_data/out_last beat stream; overflow and level status.
// Latency: first beat is valid two cycles after a capture into an empty block.
// Backpressure: beats hold while out_ready=0; when the FIFO is full and not
// popping, captures are dropped and overflow is set.
module chip_result_packer
    import chip_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture,
    input  logic [15:0]              mux_out,
    input  logic [31:0]              m32_out,
    input  logic [3:0]               flags,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic                     out_last,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    pk_state_t            r_state;
    pk_state_t            w_state_nxt;
    logic [1:0]           r_beat;
    logic [1:0]           w_beat_nxt;
    result_rec_t          r_rec;
    logic [3:0]           r_seq;
    logic                 r_ovf;

    logic                 w_load;
    logic                 w_fire;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    result_rec_t          w_head;
    result_rec_t          w_wr_rec;
    logic [$clog2(DEPTH):0] w_count;

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    assign w_wr_rec = '{flags: flags, seq: r_seq, mux: mux_out, prod: m32_out};

    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_accept),
        .wr_data (w_wr_rec),
        .rd_en   (w_load),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // ------------------------------------------------------------------
    // Capture acceptance: a pop in the same cycle frees the slot, so a
    // capture against a full FIFO is only dropped when nothing leaves.
    // ------------------------------------------------------------------
    assign w_accept = capture && (!w_full || w_load);
    assign w_drop   = capture && !w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq <= '0;
        end else if (w_accept) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    // Drop wins over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: IDLE waits for a record, SEND walks the four beats.
    // ------------------------------------------------------------------
    assign w_fire = (r_state == SEND) && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                    w_beat_nxt  = 2'd0;
                end
            end
            SEND: begin
                if (w_fire) begin
                    if (r_beat == 2'd3) begin
                        w_beat_nxt = 2'd0;
                        // Chain straight into the next record: no bubble.
                        if (!w_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_beat_nxt = r_beat + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_beat_nxt  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
            r_rec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_load) begin
                r_rec <= w_head;
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat mux. Driven purely from registers, so the beat is stable while
    // out_ready is low. Outputs are forced to zero outside SEND.
    // ------------------------------------------------------------------
    always_comb begin
        out_data = 16'h0000;
        if (r_state == SEND) begin
            case (r_beat)
                2'd0:    out_data = {r_rec.flags, r_rec.seq, SYNC};
                2'd1:    out_data = r_rec.mux;
                2'd2:    out_data = r_rec.prod[31:16];
                default: out_data = r_rec.prod[15:0];
            endcase
        end
    end

    assign out_valid = (r_state == SEND);
    assign out_last  = (r_state == SEND) && (r_beat == 2'd3);
    assign overflow  = r_ovf;
    assign level     = w_count;

endmodule : chip_result_packer

// File: tb/tb_chip_result_packer.sv
module tb_chip_result_packer;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          capture;
    logic [15:0]   mux_out;
    logic [31:0]   m32_out;
    logic [3:0]    flags;
    logic          clr_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          out_last;
    logic          overflow;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    chip_result_packer #(
        .DEPTH (DEPTH),
        .SYNC  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .mux_out   (mux_out),
        .m32_out   (m32_out),
        .flags     (flags),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .level     (level)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of pending records plus the record in the
    // output stage. Stepped once per clock at the negedge using the inputs
    // that were stable across the preceding posedge.
    // ------------------------------------------------------------------
    logic [55:0] mq[$];
    logic [55:0] m_rec;
    bit          m_busy;
    int          m_beat;
    int          m_seq;
    bit          m_ovf;
    bit          m_done, m_pop, m_drop;

    function automatic logic [15:0] beat_of(input logic [55:0] r, input int b);
        case (b)
            0:       return {r[55:48], 8'hA5};
            1:       return r[47:32];
            2:       return r[31:16];
            default: return r[15:0];
        endcase
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            mq.delete();
            m_busy = 0;
            m_beat = 0;
            m_seq  = 0;
            m_ovf  = 0;
        end else begin
            m_done = m_busy && out_ready && (m_beat == 3);
            m_pop  = (mq.size() > 0) && (!m_busy || m_done);
            m_drop = capture && (mq.size() == DEPTH) && !m_pop;
            if (m_busy && out_ready) begin
                if (m_beat == 3) m_busy = 0;
                else             m_beat = m_beat + 1;
            end
            if (m_pop) begin
                m_rec  = mq.pop_front();
                m_busy = 1;
                m_beat = 0;
            end
            if (capture && !m_drop) begin
                mq.push_back({flags, m_seq[3:0], mux_out, m32_out});
                m_seq = (m_seq + 1) % 16;
            end
            if (m_drop)       m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
        check("m_valid", out_valid, m_busy);
        check("m_data",  out_data,  m_busy ? beat_of(m_rec, m_beat) : 16'h0000);
        check("m_last",  out_last,  m_busy && (m_beat == 3));
        check("m_level", level,     mq.size());
        check("m_ovf",   overflow,  m_ovf);
    end

    // Log of transferred beats as the DUT presented them.
    logic [15:0] log_d[$];
    logic        log_l[$];
    int          log_c[$];

    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            log_d.push_back(out_data);
            log_l.push_back(out_last);
            log_c.push_back(cyc);
        end
    end

    task automatic clear_log();
        log_d.delete();
        log_l.delete();
        log_c.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        capture = 1'b0;
        clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cap(input logic [3:0] f, input logic [15:0] m, input logic [31:0] p);
        capture = 1'b1;
        flags   = f;
        mux_out = m;
        m32_out = p;
        tick();
        capture = 1'b0;
    endtask

    initial begin
        rst = 1'b1; capture = 1'b0; mux_out = '0; m32_out = '0;
        flags = '0; clr_ovf = 1'b0; out_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_data",  out_data,  16'h0000);
        check("rst_last",  out_last,  1'b0);
        check("rst_ovf",   overflow,  1'b0);
        check("rst_level", level,     0);

        // Single record and first-beat latency
        out_ready = 1'b1;
        clear_log();
        cap(4'b1010, 16'h1234, 32'hDEADBEEF);
        check("lat_c1", out_valid, 1'b0);
        tick();
        check("lat_c2", out_valid, 1'b1);
        repeat (6) tick();
        check("single_n", log_d.size(), 4);
        if (log_d.size() == 4) begin
            check("single_b0", log_d[0], 16'hA0A5);
            check("single_b1", log_d[1], 16'h1234);
            check("single_b2", log_d[2], 16'hDEAD);
            check("single_b3", log_d[3], 16'hBEEF);
            check("single_last", {log_l[0], log_l[1], log_l[2], log_l[3]}, 4'b0001);
        end

        // Back-to-back captures, no bubble
        do_reset();
        clear_log();
        out_ready = 1'b1;
        begin
            int maxlvl;
            maxlvl = 0;
            for (int i = 0; i < 3; i++) begin
                cap($urandom_range(15, 0), $urandom, $urandom);
                capture = (i < 2);
                if (int'(level) > maxlvl) maxlvl = int'(level);
            end
            capture = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (int'(level) > maxlvl) maxlvl = int'(level);
            end
            check("b2b_peak", maxlvl, 2);
        end
        check("b2b_n", log_d.size(), 12);
        if (log_d.size() == 12) begin
            for (int i = 1; i < 12; i++) check("b2b_gap", log_c[i] - log_c[0], i);
            for (int k = 0; k < 3; k++) check("b2b_seq", log_d[4*k][11:8], k);
            check("b2b_last", log_l[11], 1'b1);
        end

        // Backpressure 1,0,0,1,...
        do_reset();
        clear_log();
        out_ready = 1'b1;
        cap(4'h5, 16'hABCD, 32'h01234567);
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 3) == 0;
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_n", log_d.size(), 4);
        if (log_d.size() == 4) begin
            check("bp_b0", log_d[0], 16'h50A5);
            check("bp_b1", log_d[1], 16'hABCD);
            check("bp_b2", log_d[2], 16'h0123);
            check("bp_b3", log_d[3], 16'h4567);
        end

        // Overflow: DEPTH+2 captures with the sink stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) cap(4'h3, 16'h0100 + 16'(i), 32'h0);
        tick();
        check("ovf_level", level, DEPTH);
        check("ovf_flag",  overflow, 1'b1);
        clear_log();
        out_ready = 1'b1;
        repeat (30) tick();
        check("ovf_n", log_d.size(), 4 * (DEPTH + 1));
        if (log_d.size() == 4 * (DEPTH + 1)) begin
            for (int k = 0; k <= DEPTH; k++) begin
                check("ovf_seq", log_d[4*k][11:8], k);
                check("ovf_mux", log_d[4*k+1], 16'h0100 + 16'(k));
            end
        end
        check("ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 1'b0);

        // Full plus pop: capture in the cycle beat 3 transfers
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) cap(4'h1, 16'(i), 32'h0);
        tick();
        check("fp_full", level, DEPTH);
        out_ready = 1'b1;
        begin
            int b;
            b = 0;
            while (!(out_valid === 1'b1 && out_last === 1'b1) && b < 20) begin
                tick();
                b++;
            end
            check("fp_wait", b < 20, 1'b1);
        end
        cap(4'hF, 16'hF00D, 32'h0);
        check("fp_level", level, DEPTH);
        check("fp_ovf",   overflow, 1'b0);
        repeat (30) tick();

        // Reset during beat 2, then seq wrap
        do_reset();
        out_ready = 1'b1;
        clear_log();
        cap(4'h2, 16'h1111, 32'h22223333);
        cap(4'h2, 16'h4444, 32'h55556666);
        begin
            int b;
            b = 0;
            while (log_d.size() < 2 && b < 20) begin
                tick();
                b++;
            end
            check("rw_wait", b < 20, 1'b1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_valid", out_valid, 1'b0);
        check("rw_level", level, 0);
        clear_log();
        for (int i = 0; i < 17; i++) begin
            cap($urandom_range(15, 0), $urandom, $urandom);
            repeat (3) tick();
        end
        repeat (10) tick();
        check("wrap_n", log_d.size(), 68);
        if (log_d.size() == 68) begin
            for (int k = 0; k < 17; k++) check("wrap_seq", log_d[4*k][11:8], k % 16);
        end
        check("wrap_ovf", overflow, 1'b0);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            capture   = ($urandom % 3) == 0;
            out_ready = ($urandom % 4) != 0;
            clr_ovf   = ($urandom % 50) == 0;
            rst       = ($urandom % 500) == 0;
            flags     = $urandom_range(15, 0);
            mux_out   = $urandom;
            m32_out   = $urandom;
            tick();
        end
        capture = 1'b0; clr_ovf = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_chip_result_packer
